// File: rtl/adc_conf_arbiter_pkg.sv
// Shared ADC configuration definitions: engine op-codes, arbiter state
// encoding and the default engine timeout.
package adc_conf_arbiter_pkg;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_RESET  = 3'b001;
  localparam logic [2:0] OP_SYNC   = 3'b010;
  localparam logic [2:0] OP_CAL    = 3'b011;
  localparam logic [2:0] OP_TEST   = 3'b100;
  localparam logic [2:0] OP_RAW_WR = 3'b111;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC_GO = 3'd1;
  localparam logic [2:0] ST_SYNC_WT = 3'd2;
  localparam logic [2:0] ST_SC_GO   = 3'd3;
  localparam logic [2:0] ST_SC_WT   = 3'd4;

  function automatic logic is_sc_state(input logic [2:0] st);
    return (st == ST_SC_GO) || (st == ST_SC_WT);
  endfunction

endpackage

// File: rtl/adc_conf_arbiter.sv
// Arbitrates the ADC serial config engine between the DCM sync sequencer
// (priority) and the slow-control register bank, with an engine timeout.
module adc_conf_arbiter
  import adc_conf_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        sync_req,
  input  logic [2:0]  sync_op,
  input  logic        sync_run,
  output logic        sync_done,
  output logic        conf_wt,
  input  logic        sc_req,
  input  logic [7:0]  sc_addr,
  input  logic [15:0] sc_data,
  output logic        sc_ack,
  output logic        eng_start,
  output logic [2:0]  eng_op,
  output logic [7:0]  eng_addr,
  output logic [15:0] eng_data,
  input  logic        eng_done,
  output logic        tmo_err
);

  logic [2:0]  state_q, state_d;
  logic        sync_pend_q, sync_pend_d;
  logic [2:0]  sync_op_q, sync_op_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_err_q, tmo_err_d;
  logic        sync_done_q, sync_done_d;
  logic        sc_ack_q, sc_ack_d;
  logic        conf_wt_q, conf_wt_d;
  logic [2:0]  eng_op_q, eng_op_d;
  logic [7:0]  eng_addr_q, eng_addr_d;
  logic [15:0] eng_data_q, eng_data_d;

  logic in_wt;
  logic expired;
  logic finish;

  assign in_wt   = (state_q == ST_SYNC_WT) || (state_q == ST_SC_WT);
  assign expired = in_wt && (cnt_q == TIMEOUT - 16'd1);
  assign finish  = in_wt && (eng_done || expired);

  always_comb begin
    // NOTE: every target gets a default up front so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_err_d   = tmo_err_q | expired;
    sync_done_d = 1'b0;
    sc_ack_d    = 1'b0;
    eng_op_d    = eng_op_q;
    eng_addr_d  = eng_addr_q;
    eng_data_d  = eng_data_q;
    sync_op_d   = sync_req ? sync_op : sync_op_q;

    case (state_q)
      ST_IDLE: begin
        if (sync_pend_q || sync_req) begin
          state_d    = ST_SYNC_GO;
          eng_op_d   = sync_req ? sync_op : sync_op_q;
          eng_addr_d = 8'h00;
          eng_data_d = 16'h0000;
        end else if (sc_req && !sync_run && !sc_ack_q) begin
          // sc_ack_q guard: the requester may still hold sc_req in the ack cycle
          state_d    = ST_SC_GO;
          eng_op_d   = OP_RAW_WR;
          eng_addr_d = sc_addr;
          eng_data_d = sc_data;
        end
      end
      ST_SYNC_GO: begin
        state_d = ST_SYNC_WT;
        cnt_d   = '0;
      end
      ST_SYNC_WT: begin
        cnt_d = cnt_q + 16'd1;
        if (finish) begin
          state_d     = ST_IDLE;
          sync_done_d = 1'b1;
        end
      end
      ST_SC_GO: begin
        state_d = ST_SC_WT;
        cnt_d   = '0;
      end
      ST_SC_WT: begin
        cnt_d = cnt_q + 16'd1;
        if (finish) begin
          state_d  = ST_IDLE;
          sc_ack_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sync_pend_d = (sync_pend_q || sync_req) && (state_d != ST_SYNC_GO);

    // Port counts as held by slow control in IDLE only when no sync will claim it.
    conf_wt_d = is_sc_state(state_d) ||
                ((state_d == ST_IDLE) && sc_req && !sync_run && !sync_pend_d &&
                 !sc_ack_d && !sc_ack_q);
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      sync_pend_q <= 1'b0;
      sync_op_q   <= '0;
      cnt_q       <= '0;
      tmo_err_q   <= 1'b0;
      sync_done_q <= 1'b0;
      sc_ack_q    <= 1'b0;
      conf_wt_q   <= 1'b0;
      eng_op_q    <= '0;
      eng_addr_q  <= '0;
      eng_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sync_pend_q <= sync_pend_d;
      sync_op_q   <= sync_op_d;
      cnt_q       <= cnt_d;
      tmo_err_q   <= tmo_err_d;
      sync_done_q <= sync_done_d;
      sc_ack_q    <= sc_ack_d;
      conf_wt_q   <= conf_wt_d;
      eng_op_q    <= eng_op_d;
      eng_addr_q  <= eng_addr_d;
      eng_data_q  <= eng_data_d;
    end
  end

  assign eng_start = (state_q == ST_SYNC_GO) || (state_q == ST_SC_GO);
  assign eng_op    = eng_op_q;
  assign eng_addr  = eng_addr_q;
  assign eng_data  = eng_data_q;
  assign sync_done = sync_done_q;
  assign sc_ack    = sc_ack_q;
  assign conf_wt   = conf_wt_q;
  assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_adc_conf_arbiter.sv
// Directed bench for adc_conf_arbiter: sync/slow-control arbitration,
// pending-sync capture, engine timeout and mid-transaction reset.
module tb_adc_conf_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        sync_req;
  logic [2:0]  sync_op;
  logic        sync_run;
  logic        sync_done;
  logic        conf_wt;
  logic        sc_req;
  logic [7:0]  sc_addr;
  logic [15:0] sc_data;
  logic        sc_ack;
  logic        eng_start;
  logic [2:0]  eng_op;
  logic [7:0]  eng_addr;
  logic [15:0] eng_data;
  logic        eng_done;
  logic        tmo_err;

  int vectors    = 0;
  int miscompares = 0;

  // Pulse counters, sampled on the falling edge.
  int n_sync_done = 0;
  int n_sc_ack    = 0;
  int n_start     = 0;
  int s_sync_done, s_sc_ack, s_start;

  adc_conf_arbiter #(.TIMEOUT(16'd16)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .sync_req  (sync_req),
    .sync_op   (sync_op),
    .sync_run  (sync_run),
    .sync_done (sync_done),
    .conf_wt   (conf_wt),
    .sc_req    (sc_req),
    .sc_addr   (sc_addr),
    .sc_data   (sc_data),
    .sc_ack    (sc_ack),
    .eng_start (eng_start),
    .eng_op    (eng_op),
    .eng_addr  (eng_addr),
    .eng_data  (eng_data),
    .eng_done  (eng_done),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sync_done) n_sync_done++;
    if (sc_ack)    n_sc_ack++;
    if (eng_start) n_start++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_sync_done = n_sync_done;
    s_sc_ack    = n_sc_ack;
    s_start     = n_start;
  endtask

  initial begin
    rstb = 1'b0; sync_req = 1'b0; sync_op = 3'b000; sync_run = 1'b0;
    sc_req = 1'b0; sc_addr = 8'h00; sc_data = 16'h0000; eng_done = 1'b0;
    #2;
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_eng_op",    32'(eng_op),    0);
    check("rst_eng_addr",  32'(eng_addr),  0);
    check("rst_eng_data",  32'(eng_data),  0);
    check("rst_sync_done", 32'(sync_done), 0);
    check("rst_sc_ack",    32'(sc_ack),    0);
    check("rst_conf_wt",   32'(conf_wt),   0);
    check("rst_tmo_err",   32'(tmo_err),   0);
    tick(); tick();
    rstb = 1'b1;
    tick();

    // Sync transaction, eng_done five cycles after sync_req.
    snap();
    sync_req = 1'b1; sync_op = 3'b010;
    tick();
    sync_req = 1'b0; sync_op = 3'b000;
    check("t1_start",   32'(eng_start), 1);
    check("t1_op",      32'(eng_op),    'h2);
    check("t1_addr",    32'(eng_addr),  'h00);
    check("t1_data",    32'(eng_data),  'h0000);
    check("t1_conf_wt", 32'(conf_wt),   0);
    tick();
    check("t1_start_drop", 32'(eng_start), 0);
    check("t1_op_held",    32'(eng_op),    'h2);
    tick(); tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("t1_sync_done", 32'(sync_done), 1);
    check("t1_sc_ack",    32'(sc_ack),    0);
    tick();
    check("t1_sync_done_pulse", 32'(sync_done), 0);
    tick();
    check("t1_n_sc_ack", 32'(n_sc_ack - s_sc_ack), 0);
    check("t1_n_done",   32'(n_sync_done - s_sync_done), 1);

    // Slow-control raw write.
    snap();
    sc_req = 1'b1; sc_addr = 8'h14; sc_data = 16'h0031;
    tick();
    check("t2_start",   32'(eng_start), 1);
    check("t2_op",      32'(eng_op),    'h7);
    check("t2_addr",    32'(eng_addr),  'h14);
    check("t2_data",    32'(eng_data),  'h0031);
    check("t2_conf_wt", 32'(conf_wt),   1);
    tick();
    check("t2_wt_conf_wt", 32'(conf_wt),   1);
    check("t2_wt_start",   32'(eng_start), 0);
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("t2_sc_ack",    32'(sc_ack),    1);
    check("t2_sync_done", 32'(sync_done), 0);
    check("t2_conf_wt_idle", 32'(conf_wt), 0);
    sc_req = 1'b0;
    tick();
    check("t2_sc_ack_pulse", 32'(sc_ack),    0);
    check("t2_no_regrant",   32'(eng_start), 0);

    // Simultaneous sync_req and sc_req: sync first.
    sync_req = 1'b1; sync_op = 3'b001;
    sc_req = 1'b1; sc_addr = 8'h20; sc_data = 16'h1234;
    tick();
    sync_req = 1'b0;
    check("t3_sync_start", 32'(eng_start), 1);
    check("t3_sync_op",    32'(eng_op),    'h1);
    check("t3_sync_addr",  32'(eng_addr),  'h00);
    check("t3_conf_wt_go", 32'(conf_wt),   0);
    tick();
    check("t3_conf_wt_wt", 32'(conf_wt),   0);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("t3_sync_done", 32'(sync_done), 1);
    tick();
    check("t3_sc_start", 32'(eng_start), 1);
    check("t3_sc_op",    32'(eng_op),    'h7);
    check("t3_sc_addr",  32'(eng_addr),  'h20);
    check("t3_sc_data",  32'(eng_data),  'h1234);
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("t3_sc_ack", 32'(sc_ack), 1);
    sc_req = 1'b0;
    tick();

    // sync_req arriving during SC_WT is held and served right after.
    snap();
    sc_req = 1'b1; sc_addr = 8'h33; sc_data = 16'hbeef;
    tick();
    check("t4_sc_start", 32'(eng_start), 1);
    tick();
    sync_req = 1'b1; sync_op = 3'b100;
    tick();
    sync_req = 1'b0; sync_op = 3'b000;
    check("t4_still_wt_start", 32'(eng_start), 0);
    check("t4_still_wt_conf",  32'(conf_wt),   1);
    check("t4_addr_held",      32'(eng_addr),  'h33);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("t4_sc_ack", 32'(sc_ack), 1);
    sc_req = 1'b0;
    tick();
    check("t4_sync_start", 32'(eng_start), 1);
    check("t4_sync_op",    32'(eng_op),    'h4);
    check("t4_sync_data",  32'(eng_data),  'h0000);
    check("t4_conf_wt",    32'(conf_wt),   0);
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("t4_sync_done", 32'(sync_done), 1);
    tick(); tick(); tick();
    check("t4_n_start", 32'(n_start - s_start), 2);

    // Engine timeout with TIMEOUT=16.
    snap();
    sync_req = 1'b1; sync_op = 3'b011;
    tick();
    sync_req = 1'b0;
    check("t5_start", 32'(eng_start), 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t5_wait_done", 32'(sync_done), 0);
      check("t5_wait_tmo",  32'(tmo_err),   0);
    end
    tick();
    check("t5_tmo_done", 32'(sync_done), 1);
    check("t5_tmo_err",  32'(tmo_err),   1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("t5_late_done_ignored", 32'(sync_done), 0);
    check("t5_late_sc_ack",       32'(sc_ack),    0);
    tick(); tick();
    check("t5_tmo_sticky", 32'(tmo_err), 1);
    check("t5_idle",       32'(eng_start), 0);
    check("t5_n_done",     32'(n_sync_done - s_sync_done), 1);

    // Reset during SC_WT drops the transaction silently.
    snap();
    sc_req = 1'b1; sc_addr = 8'h55; sc_data = 16'h00aa;
    tick();
    check("t6_start", 32'(eng_start), 1);
    tick();
    check("t6_tmo_before_rst", 32'(tmo_err), 1);
    rstb = 1'b0;
    #1;
    check("t6_rst_start",   32'(eng_start), 0);
    check("t6_rst_op",      32'(eng_op),    0);
    check("t6_rst_addr",    32'(eng_addr),  0);
    check("t6_rst_data",    32'(eng_data),  0);
    check("t6_rst_conf_wt", 32'(conf_wt),   0);
    check("t6_rst_sc_ack",  32'(sc_ack),    0);
    check("t6_rst_tmo",     32'(tmo_err),   0);
    tick(); tick();
    rstb = 1'b1;
    tick();
    check("t6_regrant_start", 32'(eng_start), 1);
    check("t6_regrant_addr",  32'(eng_addr),  'h55);
    check("t6_regrant_data",  32'(eng_data),  'h00aa);
    check("t6_no_ack",        32'(n_sc_ack - s_sc_ack), 0);
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("t6_sc_ack", 32'(sc_ack), 1);
    sc_req = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
